rf_writeback_arbiter: RTL and testbench

- Shares the two register-file write ports between three writeback requesters: ALU result, memory load, and multiply/divide.
- Multiply/divide writes a dual result: low word to Rd, high word/remainder to R15.
- Sits between the WB-stage sources and the RegisterFile.
- Owns the WriteReg1/2, WriteData1/2, RegWrite and WriteOP2 drive, with a starvation guard so no requester waits indefinitely.

---
 rtl/rf_pkg.sv | 16 +
 rtl/rf_starve_ctr.sv | 35 +++
 rtl/rf_writeback_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_rf_writeback_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package rf_pkg;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;
  localparam logic [AW-1:0] HI_REG = AW'(15);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {REQ_MD, REQ_MEM, REQ_ALU} req_idx_e;

endpackage

// File: rtl/rf_starve_ctr.sv
// Saturating count of consecutive denied cycles; boost once the limit is reached.
module rf_starve_ctr #(
  parameter int unsigned LIMIT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  input  logic ready,
  output logic boost
);

  localparam logic [2:0] Limit = 3'(LIMIT);

  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!valid || ready) begin
      cnt_d = '0;
    end else if (cnt_q != Limit) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign boost = (cnt_q == Limit);

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Arbitrates ALU, load and mul/div writebacks onto the two register-file write ports,
// registering the chosen writes for one cycle.
module rf_writeback_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_rd,
  input  logic [DW-1:0] mem_data,
  output logic          mem_ready,
  input  logic          md_valid,
  input  logic [AW-1:0] md_rd,
  input  logic [DW-1:0] md_lo,
  input  logic [DW-1:0] md_hi,
  output logic          md_ready,
  output logic [AW-1:0] wr_reg1,
  output logic [DW-1:0] wr_data1,
  output logic [AW-1:0] wr_reg2,
  output logic [DW-1:0] wr_data2,
  output logic          reg_write,
  output logic          write_op2,
  output logic          alu_boost,
  output logic          mem_boost
);

  wb_req_t alu_req, mem_req, md_req;

  assign alu_req = {alu_valid, alu_rd, alu_data};
  assign mem_req = {mem_valid, mem_rd, mem_data};
  assign md_req  = {md_valid, md_rd, md_lo};

  req_idx_e order [3];

  always_comb begin
    case ({mem_boost, alu_boost})
      2'b10:   order = '{REQ_MEM, REQ_MD, REQ_ALU};
      2'b01:   order = '{REQ_ALU, REQ_MD, REQ_MEM};
      2'b11:   order = '{REQ_MEM, REQ_ALU, REQ_MD};
      default: order = '{REQ_MD, REQ_MEM, REQ_ALU};
    endcase
  end

  logic          p1_used, p2_used;
  logic [AW-1:0] p1_rd;
  logic          md_gnt, mem_gnt, alu_gnt, mem_p2, alu_p2;

  // Ports fill in order, so port 2 is free exactly when a slot remains. Once md holds the
  // ports nothing else fits, so the only possible clash is with the single on port 1.
  always_comb begin
    p1_used = 1'b0;
    p2_used = 1'b0;
    p1_rd   = '0;
    md_gnt  = 1'b0;
    mem_gnt = 1'b0;
    alu_gnt = 1'b0;
    mem_p2  = 1'b0;
    alu_p2  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      case (order[i])
        REQ_MD: begin
          if (md_req.valid && !p1_used && !p2_used) begin
            md_gnt  = 1'b1;
            p1_used = 1'b1;
            p2_used = 1'b1;
          end
        end
        REQ_MEM: begin
          if (mem_req.valid && !p2_used && !(p1_used && mem_req.rd == p1_rd)) begin
            mem_gnt = 1'b1;
            if (p1_used) begin
              mem_p2  = 1'b1;
              p2_used = 1'b1;
            end else begin
              p1_used = 1'b1;
              p1_rd   = mem_req.rd;
            end
          end
        end
        REQ_ALU: begin
          if (alu_req.valid && !p2_used && !(p1_used && alu_req.rd == p1_rd)) begin
            alu_gnt = 1'b1;
            if (p1_used) begin
              alu_p2  = 1'b1;
              p2_used = 1'b1;
            end else begin
              p1_used = 1'b1;
              p1_rd   = alu_req.rd;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign md_ready  = md_gnt & rst;
  assign mem_ready = mem_gnt & rst;
  assign alu_ready = alu_gnt & rst;

  rf_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_alu_ctr (
    .clk   (clk),
    .rst   (rst),
    .valid (alu_valid),
    .ready (alu_ready),
    .boost (alu_boost)
  );

  rf_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_mem_ctr (
    .clk   (clk),
    .rst   (rst),
    .valid (mem_valid),
    .ready (mem_ready),
    .boost (mem_boost)
  );

  logic [AW-1:0] wr_reg1_q, wr_reg1_d, wr_reg2_q, wr_reg2_d;
  logic [DW-1:0] wr_data1_q, wr_data1_d, wr_data2_q, wr_data2_d;
  logic          reg_write_q, reg_write_d, write_op2_q, write_op2_d;

  always_comb begin
    wr_reg1_d   = wr_reg1_q;
    wr_data1_d  = wr_data1_q;
    wr_reg2_d   = wr_reg2_q;
    wr_data2_d  = wr_data2_q;
    reg_write_d = 1'b0;
    write_op2_d = 1'b0;
    if (md_ready) begin
      wr_reg1_d   = md_req.rd;
      wr_data1_d  = md_req.data;
      reg_write_d = (md_req.rd != HI_REG);  // high word wins when both target HI_REG
      wr_reg2_d   = HI_REG;
      wr_data2_d  = md_hi;
      write_op2_d = 1'b1;
    end else begin
      if (mem_ready) begin
        if (mem_p2) begin
          wr_reg2_d   = mem_req.rd;
          wr_data2_d  = mem_req.data;
          write_op2_d = 1'b1;
        end else begin
          wr_reg1_d   = mem_req.rd;
          wr_data1_d  = mem_req.data;
          reg_write_d = 1'b1;
        end
      end
      if (alu_ready) begin
        if (alu_p2) begin
          wr_reg2_d   = alu_req.rd;
          wr_data2_d  = alu_req.data;
          write_op2_d = 1'b1;
        end else begin
          wr_reg1_d   = alu_req.rd;
          wr_data1_d  = alu_req.data;
          reg_write_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_reg1_q   <= '0;
      wr_data1_q  <= '0;
      wr_reg2_q   <= '0;
      wr_data2_q  <= '0;
      reg_write_q <= 1'b0;
      write_op2_q <= 1'b0;
    end else begin
      wr_reg1_q   <= wr_reg1_d;
      wr_data1_q  <= wr_data1_d;
      wr_reg2_q   <= wr_reg2_d;
      wr_data2_q  <= wr_data2_d;
      reg_write_q <= reg_write_d;
      write_op2_q <= write_op2_d;
    end
  end

  assign wr_reg1   = wr_reg1_q;
  assign wr_data1  = wr_data1_q;
  assign wr_reg2   = wr_reg2_q;
  assign wr_data2  = wr_data2_q;
  assign reg_write = reg_write_q;
  assign write_op2 = write_op2_q;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Bench for rf_writeback_arbiter: directed scenarios pinned by literals, then random
// traffic checked every cycle against a queue-based priority model.
module tb_rf_writeback_arbiter;
  import rf_pkg::*;

  localparam int LIM = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          alu_valid = 1'b0, mem_valid = 1'b0, md_valid = 1'b0;
  logic [AW-1:0] alu_rd = '0, mem_rd = '0, md_rd = '0;
  logic [DW-1:0] alu_data = '0, mem_data = '0, md_lo = '0, md_hi = '0;
  logic          alu_ready, mem_ready, md_ready;
  logic [AW-1:0] wr_reg1, wr_reg2;
  logic [DW-1:0] wr_data1, wr_data2;
  logic          reg_write, write_op2, alu_boost, mem_boost;

  always #5 clk = ~clk;

  rf_writeback_arbiter #(
    .STARVE_LIMIT (LIM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .md_valid  (md_valid),
    .md_rd     (md_rd),
    .md_lo     (md_lo),
    .md_hi     (md_hi),
    .md_ready  (md_ready),
    .wr_reg1   (wr_reg1),
    .wr_data1  (wr_data1),
    .wr_reg2   (wr_reg2),
    .wr_data2  (wr_data2),
    .reg_write (reg_write),
    .write_op2 (write_op2),
    .alu_boost (alu_boost),
    .mem_boost (mem_boost)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_alu = 0;
  int cnt_mem = 0;
  bit g_md, g_mem, g_alu;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_md(input bit v, input int rd, input int lo, input int hi);
    md_valid = v; md_rd = AW'(rd); md_lo = DW'(lo); md_hi = DW'(hi);
  endtask

  task automatic set_mem(input bit v, input int rd, input int d);
    mem_valid = v; mem_rd = AW'(rd); mem_data = DW'(d);
  endtask

  task automatic set_alu(input bit v, input int rd, input int d);
    alu_valid = v; alu_rd = AW'(rd); alu_data = DW'(d);
  endtask

  // Model: ids 0=md, 1=mem, 2=alu. Boosted singles first (mem before alu), then md,
  // then remaining singles. Tracks free port count and the destinations already claimed.
  task automatic model_grant(output bit gmd, output bit gmem, output bit galu,
                             output int pmem, output int palu);
    int order[$];
    int dests[$];
    int free_ports, next_port;
    bit bm, ba;
    bm = (cnt_mem == LIM);
    ba = (cnt_alu == LIM);
    gmd = 0; gmem = 0; galu = 0; pmem = 0; palu = 0;
    free_ports = 2; next_port = 1;
    if (bm) order.push_back(1);
    if (ba) order.push_back(2);
    order.push_back(0);
    if (!bm) order.push_back(1);
    if (!ba) order.push_back(2);
    foreach (order[i]) begin
      if (order[i] == 0) begin
        if (md_valid && free_ports == 2) begin
          gmd = 1; free_ports = 0;
          dests.push_back(int'(md_rd));
          dests.push_back(15);
        end
      end else begin
        bit v, clash;
        int rd;
        v  = (order[i] == 1) ? mem_valid : alu_valid;
        rd = (order[i] == 1) ? int'(mem_rd) : int'(alu_rd);
        clash = 0;
        foreach (dests[j]) if (dests[j] == rd) clash = 1;
        if (v && free_ports > 0 && !clash) begin
          if (order[i] == 1) begin gmem = 1; pmem = next_port; end
          else begin galu = 1; palu = next_port; end
          next_port++; free_ports--;
          dests.push_back(rd);
        end
      end
    end
  endtask

  // Called mid-cycle with inputs stable; checks readies now and writes after the edge.
  task automatic step();
    int pm, pa;
    bit e_rw, e_op2;
    int er1, ed1, er2, ed2;
    #1;
    model_grant(g_md, g_mem, g_alu, pm, pa);
    check("md_ready", md_ready, g_md);
    check("mem_ready", mem_ready, g_mem);
    check("alu_ready", alu_ready, g_alu);
    check("mem_boost", mem_boost, cnt_mem == LIM);
    check("alu_boost", alu_boost, cnt_alu == LIM);
    e_rw = 0; e_op2 = 0; er1 = 0; ed1 = 0; er2 = 0; ed2 = 0;
    if (g_md) begin
      e_rw = (md_rd != 15); er1 = md_rd; ed1 = md_lo;
      e_op2 = 1; er2 = 15; ed2 = md_hi;
    end
    if (g_mem) begin
      if (pm == 1) begin e_rw = 1; er1 = mem_rd; ed1 = mem_data; end
      else begin e_op2 = 1; er2 = mem_rd; ed2 = mem_data; end
    end
    if (g_alu) begin
      if (pa == 1) begin e_rw = 1; er1 = alu_rd; ed1 = alu_data; end
      else begin e_op2 = 1; er2 = alu_rd; ed2 = alu_data; end
    end
    if (!alu_valid || g_alu) cnt_alu = 0; else if (cnt_alu < LIM) cnt_alu++;
    if (!mem_valid || g_mem) cnt_mem = 0; else if (cnt_mem < LIM) cnt_mem++;
    @(posedge clk);
    #1;
    check("reg_write", reg_write, e_rw);
    check("write_op2", write_op2, e_op2);
    if (e_rw) begin
      check("wr_reg1", wr_reg1, er1);
      check("wr_data1", wr_data1, ed1);
    end
    if (e_op2) begin
      check("wr_reg2", wr_reg2, er2);
      check("wr_data2", wr_data2, ed2);
    end
  endtask

  function automatic int pick_single_rd();
    return $urandom_range(4, 7);
  endfunction

  initial begin
    // Reset held with every requester asking.
    rst = 1'b0;
    set_md(1, 2, 'h0101, 'h0202);
    set_mem(1, 5, 'h0022);
    set_alu(1, 3, 'h0011);
    repeat (3) @(posedge clk);
    #1;
    check("rst_md_ready", md_ready, 0);
    check("rst_mem_ready", mem_ready, 0);
    check("rst_alu_ready", alu_ready, 0);
    check("rst_reg_write", reg_write, 0);
    check("rst_write_op2", write_op2, 0);
    check("rst_wr_reg1", wr_reg1, 0);
    check("rst_wr_data2", wr_data2, 0);
    check("rst_alu_boost", alu_boost, 0);
    check("rst_mem_boost", mem_boost, 0);

    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rel_md_ready", md_ready, 1);
    step();
    check("rel_wr_reg2", wr_reg2, 15);
    check("rel_wr_data1", wr_data1, 'h0101);

    // Two singles: mem lands on port 1, alu on port 2.
    set_md(0, 0, 0, 0);
    step();
    check("two_wr_reg1", wr_reg1, 5);
    check("two_wr_data1", wr_data1, 'h0022);
    check("two_wr_reg2", wr_reg2, 3);
    check("two_wr_data2", wr_data2, 'h0011);

    // Mul/div beats a concurrent ALU request.
    set_md(1, 2, 'hBEEF, 'h1234);
    set_alu(1, 3, 'h0033);
    set_mem(0, 0, 0);
    #1;
    check("md_wins_md_ready", md_ready, 1);
    check("md_wins_alu_ready", alu_ready, 0);
    step();
    check("md_wr_reg1", wr_reg1, 2);
    check("md_wr_data1", wr_data1, 'hBEEF);
    check("md_wr_reg2", wr_reg2, 15);
    check("md_wr_data2", wr_data2, 'h1234);
    check("md_reg_write", reg_write, 1);
    set_md(0, 0, 0, 0);
    step();

    // Same-destination conflict.
    set_alu(1, 7, 'h0077);
    set_mem(1, 7, 'h0070);
    #1;
    check("conf_mem_ready", mem_ready, 1);
    check("conf_alu_ready", alu_ready, 0);
    step();
    check("conf_wr_data1", wr_data1, 'h0070);
    check("conf_write_op2", write_op2, 0);
    set_mem(0, 0, 0);
    step();
    check("conf_alu_wr_reg1", wr_reg1, 7);
    check("conf_alu_wr_data1", wr_data1, 'h0077);
    check("conf_alu_reg_write", reg_write, 1);

    // Starvation: ALU denied three times behind md, then boosted past it.
    set_alu(1, 4, 'h0044);
    for (int k = 0; k < 3; k++) begin
      set_md(1, 9, 'h0900 + k, 'h0A00 + k);
      step();
    end
    check("starve_boost_up", alu_boost, 1);
    set_md(1, 9, 'h0999, 'h0AAA);
    #1;
    check("starve_alu_ready", alu_ready, 1);
    check("starve_md_ready", md_ready, 0);
    step();
    check("starve_wr_reg1", wr_reg1, 4);
    check("starve_wr_data1", wr_data1, 'h0044);
    check("starve_boost_down", alu_boost, 0);
    set_alu(0, 0, 0);
    step();

    // md targeting HI_REG writes only the high word.
    set_md(1, 15, 'hAAAA, 'h5555);
    step();
    check("hi_reg_write", reg_write, 0);
    check("hi_write_op2", write_op2, 1);
    check("hi_wr_reg2", wr_reg2, 15);
    check("hi_wr_data2", wr_data2, 'h5555);

    // Reset between grant and edge drops the pending write.
    set_md(1, 1, 'h1111, 'h2222);
    #2;
    check("mid_md_ready", md_ready, 1);
    rst = 1'b0;
    #1;
    check("mid_md_ready_rst", md_ready, 0);
    @(posedge clk);
    #1;
    check("mid_reg_write", reg_write, 0);
    check("mid_write_op2", write_op2, 0);
    cnt_alu = 0;
    cnt_mem = 0;
    @(negedge clk);
    rst = 1'b1;
    g_md = 0; g_mem = 0; g_alu = 0;

    // Random traffic; an ungranted requester holds its request unchanged.
    for (int c = 0; c < 3000; c++) begin
      if (!md_valid || g_md) begin
        if ($urandom_range(0, 9) < 6)
          set_md(1, ($urandom_range(0, 3) == 0) ? 15 : pick_single_rd(),
                 $urandom_range(0, 'hFFFF), $urandom_range(0, 'hFFFF));
        else
          set_md(0, 0, 0, 0);
      end
      if (!mem_valid || g_mem) begin
        if ($urandom_range(0, 9) < 7) set_mem(1, pick_single_rd(), $urandom_range(0, 'hFFFF));
        else set_mem(0, 0, 0);
      end
      if (!alu_valid || g_alu) begin
        if ($urandom_range(0, 9) < 7) set_alu(1, pick_single_rd(), $urandom_range(0, 'hFFFF));
        else set_alu(0, 0, 0);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
